// File: rtl/render_pkg.sv
// Shared types and helpers for the render-to-framebuffer path.
// Pixel records, writer FSM states and framebuffer size limits live here.
package render_pkg;

    localparam int unsigned MAX_NPIX = 65536;

    function automatic int unsigned calc_npix(input int unsigned width, input int unsigned height);
        return width * height;
    endfunction

    typedef struct packed {
        logic [15:0] addr;
        logic [15:0] color;
    } pixel_t;

    typedef enum logic [1:0] {
        IDLE,
        CLEAR,
        DRAW,
        FLUSH
    } fw_state_t;

endpackage

// File: rtl/pixel_fifo.sv
// Small synchronous FIFO of pixel records with show-ahead read data.
// Pushes while full and pops while empty are ignored.
module pixel_fifo
    import render_pkg::*;
#(
    parameter int unsigned DEPTH = 8
) (
    input  logic   i_clk,
    input  logic   i_rst_n,
    input  logic   i_push,
    input  pixel_t i_data,
    input  logic   i_pop,
    output pixel_t o_data,
    output logic   o_full,
    output logic   o_empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    // Pointers carry one extra wrap bit to tell full from empty.
    logic [AW:0] r_wr_ptr;
    logic [AW:0] r_rd_ptr;
    pixel_t      r_mem [DEPTH];
    logic        w_push;
    logic        w_pop;

    assign o_empty = (r_wr_ptr == r_rd_ptr);
    assign o_full  = (r_wr_ptr[AW] != r_rd_ptr[AW]) && (r_wr_ptr[AW-1:0] == r_rd_ptr[AW-1:0]);
    assign w_push  = i_push && !o_full;
    assign w_pop   = i_pop && !o_empty;
    assign o_data  = r_mem[r_rd_ptr[AW-1:0]];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
        end else begin
            if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
            if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge i_clk) begin
        if (w_push) r_mem[r_wr_ptr[AW-1:0]] <= i_data;
    end

endmodule

// File: rtl/frame_writer.sv
// Writes the render pixel stream into the back bank of a double-buffered framebuffer:
// clear, buffer pixels arriving during the clear, drain, then swap banks.
module frame_writer
    import render_pkg::*;
#(
    parameter int unsigned WIDTH       = 320,
    parameter int unsigned HEIGHT      = 180,
    parameter int unsigned FIFO_DEPTH  = 8,
    parameter logic [15:0] CLEAR_COLOR = 16'h0000
) (
    input  logic        clk_in,
    input  logic        rst_in,
    input  logic        frame_start_in,
    input  logic        frame_done_in,
    input  logic        pixel_valid_in,
    input  logic [15:0] pixel_addr_in,
    input  logic [15:0] pixel_color_in,
    output logic        ready_out,
    output logic        bram_we_out,
    output logic [16:0] bram_addr_out,
    output logic [15:0] bram_data_out,
    output logic        display_bank_out,
    output logic        swap_out,
    output logic        busy_out,
    output logic        overflow_out,
    output logic        addr_err_out
);

    localparam int unsigned NPIX     = calc_npix(WIDTH, HEIGHT);
    localparam logic [16:0] NPIX_W   = 17'(NPIX);
    localparam logic [15:0] LAST_PTR = 16'(NPIX - 1);

    if (NPIX > MAX_NPIX || NPIX == 0) begin : g_npix_check
        $error("frame_writer: WIDTH*HEIGHT must be in 1..65536");
    end

    fw_state_t   r_state;
    logic [15:0] r_clear_ptr;
    logic        r_done_pending;
    logic        r_display_bank;
    logic        r_bram_we;
    logic [16:0] r_bram_addr;
    logic [15:0] r_bram_data;
    logic        r_swap;
    logic        r_overflow;
    logic        r_addr_err;

    logic        w_draw_bank;
    logic        w_full;
    logic        w_empty;
    logic        w_ready;
    logic        w_accept;
    logic        w_addr_ok;
    logic        w_push;
    logic        w_pop;
    pixel_t      w_pix_in;
    pixel_t      w_pix_out;

    assign w_draw_bank = ~r_display_bank;
    assign w_ready     = ((r_state == CLEAR) || (r_state == DRAW)) && !w_full;
    assign w_accept    = pixel_valid_in && w_ready;
    assign w_addr_ok   = ({1'b0, pixel_addr_in} < NPIX_W);
    assign w_push      = w_accept && w_addr_ok;
    // The clear owns the BRAM port, so the FIFO only drains after it.
    assign w_pop       = ((r_state == DRAW) || (r_state == FLUSH)) && !w_empty;
    assign w_pix_in    = {pixel_addr_in, pixel_color_in};

    pixel_fifo #(
        .DEPTH(FIFO_DEPTH)
    ) u_pixel_fifo (
        .i_clk  (clk_in),
        .i_rst_n(rst_in),
        .i_push (w_push),
        .i_data (w_pix_in),
        .i_pop  (w_pop),
        .o_data (w_pix_out),
        .o_full (w_full),
        .o_empty(w_empty)
    );

    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            r_state        <= IDLE;
            r_clear_ptr    <= '0;
            r_done_pending <= 1'b0;
            r_display_bank <= 1'b0;
            r_bram_we      <= 1'b0;
            r_bram_addr    <= '0;
            r_bram_data    <= '0;
            r_swap         <= 1'b0;
            r_overflow     <= 1'b0;
            r_addr_err     <= 1'b0;
        end else begin
            r_bram_we <= 1'b0;
            r_swap    <= 1'b0;
            if (w_pop) begin
                r_bram_we   <= 1'b1;
                r_bram_addr <= {w_draw_bank, w_pix_out.addr};
                r_bram_data <= w_pix_out.color;
            end
            case (r_state)
                IDLE: begin
                    if (frame_start_in) begin
                        r_state        <= CLEAR;
                        r_clear_ptr    <= '0;
                        r_done_pending <= 1'b0;
                        r_overflow     <= 1'b0;
                        r_addr_err     <= 1'b0;
                    end
                end
                CLEAR: begin
                    r_bram_we   <= 1'b1;
                    r_bram_addr <= {w_draw_bank, r_clear_ptr};
                    r_bram_data <= CLEAR_COLOR;
                    r_clear_ptr <= r_clear_ptr + 16'd1;
                    if (frame_done_in) r_done_pending <= 1'b1;
                    if (r_clear_ptr == LAST_PTR) r_state <= DRAW;
                end
                DRAW: begin
                    if (frame_done_in || r_done_pending) begin
                        r_state        <= FLUSH;
                        r_done_pending <= 1'b0;
                    end
                end
                FLUSH: begin
                    // Swap only once the last drained write has left the output register.
                    if (w_empty && !r_bram_we) begin
                        r_display_bank <= w_draw_bank;
                        r_swap         <= 1'b1;
                        r_state        <= IDLE;
                    end
                end
                default: r_state <= IDLE;
            endcase
            if (pixel_valid_in && !w_ready) r_overflow <= 1'b1;
            if (w_accept && !w_addr_ok)     r_addr_err <= 1'b1;
        end
    end

    assign ready_out        = w_ready;
    assign busy_out         = (r_state != IDLE);
    assign bram_we_out      = r_bram_we;
    assign bram_addr_out    = r_bram_addr;
    assign bram_data_out    = r_bram_data;
    assign display_bank_out = r_display_bank;
    assign swap_out         = r_swap;
    assign overflow_out     = r_overflow;
    assign addr_err_out     = r_addr_err;

endmodule

// File: tb/tb_frame_writer.sv
// Scoreboard bench for frame_writer: a frame-level model predicts every BRAM write,
// acceptance, flags and bank swaps; a monitor checks writes as they appear.
module tb_frame_writer;

    localparam int unsigned W  = 4;
    localparam int unsigned H  = 2;
    localparam int unsigned D  = 4;
    localparam int unsigned NP = W * H;

    logic        clk;
    logic        rst_n;
    logic        frame_start;
    logic        frame_done;
    logic        pix_valid;
    logic [15:0] pix_addr;
    logic [15:0] pix_color;
    logic        ready;
    logic        bram_we;
    logic [16:0] bram_addr;
    logic [15:0] bram_data;
    logic        disp_bank;
    logic        swap;
    logic        busy;
    logic        ovf;
    logic        aerr;

    frame_writer #(
        .WIDTH      (W),
        .HEIGHT     (H),
        .FIFO_DEPTH (D),
        .CLEAR_COLOR(16'h0000)
    ) dut (
        .clk_in          (clk),
        .rst_in          (rst_n),
        .frame_start_in  (frame_start),
        .frame_done_in   (frame_done),
        .pixel_valid_in  (pix_valid),
        .pixel_addr_in   (pix_addr),
        .pixel_color_in  (pix_color),
        .ready_out       (ready),
        .bram_we_out     (bram_we),
        .bram_addr_out   (bram_addr),
        .bram_data_out   (bram_data),
        .display_bank_out(disp_bank),
        .swap_out        (swap),
        .busy_out        (busy),
        .overflow_out    (ovf),
        .addr_err_out    (aerr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [16:0] a;
        logic [15:0] d;
    } wr_t;

    typedef struct {
        int          cyc;
        logic [15:0] a;
        logic [15:0] c;
    } dpix_t;

    wr_t   exp_q[$];
    dpix_t dir_q[$];
    int    total = 0;
    int    bad = 0;
    bit    m_disp = 1'b0;
    bit    m_ovf = 1'b0;
    bit    m_aerr = 1'b0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
        total++;
        if (act !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, expv, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Monitor: every BRAM write must match the oldest predicted write.
    initial begin
        wr_t e;
        forever begin
            @(negedge clk);
            if (rst_n && bram_we) begin
                total++;
                if (exp_q.size() == 0) begin
                    bad++;
                    $display("FAIL unexpected_write: got addr %0h data %0h expected none",
                             bram_addr, bram_data);
                end else begin
                    e = exp_q.pop_front();
                    if (bram_addr !== e.a || bram_data !== e.d) begin
                        bad++;
                        $display("FAIL write: got %0h=%0h expected %0h=%0h",
                                 bram_addr, bram_data, e.a, e.d);
                    end
                end
            end
        end
    end

    task automatic do_reset_check();
        #1;
        rst_n = 1'b0;
        #1;
        chk("rst_we", 32'(bram_we), 0);
        chk("rst_addr", 32'(bram_addr), 0);
        chk("rst_data", 32'(bram_data), 0);
        chk("rst_swap", 32'(swap), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_ready", 32'(ready), 0);
        chk("rst_disp", 32'(disp_bank), 0);
        chk("rst_ovf", 32'(ovf), 0);
        chk("rst_aerr", 32'(aerr), 0);
        exp_q.delete();
        dir_q.delete();
        m_disp = 1'b0;
        m_ovf  = 1'b0;
        m_aerr = 1'b0;
        pix_valid  = 1'b0;
        frame_done = 1'b0;
        repeat (3) tick();
        rst_n = 1'b1;
        for (int k = 0; k < 12; k++) begin
            tick();
            chk("post_rst_noswap", 32'(swap), 0);
            chk("post_rst_disp", 32'(disp_bank), 0);
        end
    endtask

    // One frame: cycle 0 issues frame_start; cycles 1..NP are the clear, then drawing.
    task automatic run_frame(input int done_at, input bit rnd, input int rst_at);
        bit          draw;
        int          cnt;
        int          last;
        int          i;
        int          lat_due;
        logic [16:0] lat_a;
        logic [15:0] lat_c;
        bit          clr;
        bit          v;
        bit          exp_ready;
        bit          pop;
        bit          push;
        bit          got;
        logic [15:0] a;
        logic [15:0] c;

        draw    = ~m_disp;
        cnt     = 0;
        lat_due = -1;
        lat_a   = '0;
        lat_c   = '0;
        last    = (done_at > int'(NP)) ? done_at : int'(NP);
        frame_start = 1'b1;
        pix_valid   = 1'b0;
        frame_done  = 1'b0;
        for (int k = 0; k < int'(NP); k++)
            exp_q.push_back('{a: {draw, 16'(k)}, d: 16'h0000});
        m_ovf  = 1'b0;
        m_aerr = 1'b0;
        tick();
        frame_start = 1'b0;
        chk("start_busy", 32'(busy), 1);
        chk("start_ovf_clr", 32'(ovf), 0);
        chk("start_aerr_clr", 32'(aerr), 0);

        for (i = 1; i <= last; i++) begin
            if (i == rst_at) begin
                do_reset_check();
                return;
            end
            if (i == lat_due) begin
                chk("lat_we", 32'(bram_we), 1);
                chk("lat_addr", 32'(bram_addr), 32'(lat_a));
                chk("lat_data", 32'(bram_data), 32'(lat_c));
            end
            clr       = (i <= int'(NP));
            exp_ready = (cnt < int'(D));
            chk("ready", 32'(ready), 32'(exp_ready));
            v = 1'b0;
            a = '0;
            c = '0;
            if (dir_q.size() > 0 && dir_q[0].cyc == i) begin
                dpix_t p;
                p = dir_q.pop_front();
                v = 1'b1;
                a = p.a;
                c = p.c;
            end else if (rnd && $urandom_range(0, 99) < 60) begin
                v = 1'b1;
                a = 16'($urandom_range(0, NP + 1));
                c = 16'($urandom);
            end
            pix_valid  = v;
            pix_addr   = a;
            pix_color  = c;
            frame_done = (i == done_at);
            pop  = !clr && cnt > 0;
            push = 1'b0;
            if (v) begin
                if (!exp_ready) begin
                    m_ovf = 1'b1;
                end else if (a < 16'(NP)) begin
                    push = 1'b1;
                    exp_q.push_back('{a: {draw, a}, d: c});
                    if (!clr && cnt == 0) begin
                        lat_due = i + 2;
                        lat_a   = {draw, a};
                        lat_c   = c;
                    end
                end else begin
                    m_aerr = 1'b1;
                end
            end
            cnt = cnt - int'(pop) + int'(push);
            tick();
        end
        pix_valid  = 1'b0;
        frame_done = 1'b0;

        got = 1'b0;
        for (int k = 0; k < 60; k++) begin
            if (i == lat_due) begin
                chk("lat_we", 32'(bram_we), 1);
                chk("lat_addr", 32'(bram_addr), 32'(lat_a));
                chk("lat_data", 32'(bram_data), 32'(lat_c));
            end
            if (swap) begin
                got = 1'b1;
                break;
            end
            tick();
            i++;
        end
        if (!got) begin
            chk("swap_seen", 0, 1);
        end else begin
            chk("writes_drained", 32'(exp_q.size()), 0);
            chk("swap_disp", 32'(disp_bank), 32'(draw));
            chk("swap_idle", 32'(busy), 0);
            chk("swap_ovf", 32'(ovf), 32'(m_ovf));
            chk("swap_aerr", 32'(aerr), 32'(m_aerr));
            m_disp = draw;
            tick();
            chk("swap_pulse_end", 32'(swap), 0);
        end
    endtask

    initial begin
        rst_n       = 1'b0;
        frame_start = 1'b0;
        frame_done  = 1'b0;
        pix_valid   = 1'b0;
        pix_addr    = '0;
        pix_color   = '0;
        repeat (2) tick();
        chk("reset_we", 32'(bram_we), 0);
        chk("reset_disp", 32'(disp_bank), 0);
        chk("reset_busy", 32'(busy), 0);
        chk("reset_ready", 32'(ready), 0);
        chk("reset_ovf", 32'(ovf), 0);
        chk("reset_aerr", 32'(aerr), 0);
        chk("reset_swap", 32'(swap), 0);
        rst_n = 1'b1;
        tick();

        // Empty frame, done arrives during the clear.
        run_frame(3, 1'b0, -1);

        // Single pixel after the clear, then a plain frame on the other bank.
        dir_q.push_back('{cyc: 10, a: 16'd5, c: 16'hF800});
        run_frame(14, 1'b0, -1);
        run_frame(5, 1'b0, -1);

        // Five back-to-back pixels during the clear overflow a 4-deep FIFO.
        for (int k = 1; k <= 5; k++)
            dir_q.push_back('{cyc: k, a: 16'(k - 1), c: 16'(16'h1110 + k)});
        run_frame(12, 1'b0, -1);

        // Out-of-range address, then a pixel offered while idle.
        dir_q.push_back('{cyc: 10, a: 16'(NP), c: 16'h1234});
        run_frame(12, 1'b0, -1);
        pix_valid = 1'b1;
        pix_addr  = 16'd3;
        pix_color = 16'hABCD;
        m_ovf     = 1'b1;
        tick();
        pix_valid = 1'b0;
        chk("idle_ovf", 32'(ovf), 1);
        chk("aerr_sticky", 32'(aerr), 1);
        chk("idle_no_start", 32'(busy), 0);

        // Done during the clear with two queued pixels.
        dir_q.push_back('{cyc: 2, a: 16'd1, c: 16'h07E0});
        dir_q.push_back('{cyc: 3, a: 16'd6, c: 16'h001F});
        run_frame(4, 1'b0, -1);

        repeat (25) run_frame(int'($urandom_range(2, 16)), 1'b1, -1);

        // Reset in the middle of drawing with the FIFO still holding pixels.
        for (int k = 1; k <= 4; k++)
            dir_q.push_back('{cyc: k, a: 16'(k + 2), c: 16'(16'hC000 + k)});
        run_frame(20, 1'b0, 10);

        repeat (3) run_frame(int'($urandom_range(2, 16)), 1'b1, -1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
